// File: rtl/tboom_freelist_multi.sv
// N-wide physical-register free list for rename: circular tag array with
// multi-lane compacted alloc/free and head-pointer checkpoints for branch recovery.
module tboom_freelist_multi #(
  parameter int unsigned PREG_COUNT       = 64,
  parameter int unsigned ARCH_REGS        = 32,
  parameter int unsigned ALLOC_PORTS      = 2,
  parameter int unsigned FREE_PORTS       = 2,
  parameter int unsigned CHECKPOINT_DEPTH = 8,
  localparam int unsigned PTAG_W = $clog2(PREG_COUNT),
  localparam int unsigned CP_W   = (CHECKPOINT_DEPTH > 1) ? $clog2(CHECKPOINT_DEPTH) : 1,
  localparam int unsigned CNT_W  = $clog2(PREG_COUNT) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ALLOC_PORTS-1:0]        alloc_req,
  output logic                          alloc_ready,
  output logic [ALLOC_PORTS*PTAG_W-1:0] alloc_tag,
  input  logic [FREE_PORTS-1:0]         free_valid,
  input  logic [FREE_PORTS*PTAG_W-1:0]  free_tag,
  input  logic                          cp_save,
  input  logic                          cp_restore,
  input  logic [CP_W-1:0]               cp_idx,
  output logic [CNT_W-1:0]              free_count,
  output logic                          empty,
  output logic                          err_overflow,
  output logic                          err_bad_restore
);

  localparam int unsigned DEPTH = PREG_COUNT - ARCH_REGS;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned LN_W  = 3;
  localparam int unsigned SUM_W = IDX_W + 4;

  // Pointer is {wrap, index}; index stays in 0..DEPTH-1 even for non-power-of-two DEPTH.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [LN_W-1:0] k);
    logic [SUM_W-1:0] s;
    s = SUM_W'(p[IDX_W-1:0]) + SUM_W'(k);
    if (s >= SUM_W'(DEPTH)) begin
      s = s - SUM_W'(DEPTH);
      return {~p[PTR_W-1], s[IDX_W-1:0]};
    end
    return {p[PTR_W-1], s[IDX_W-1:0]};
  endfunction

  function automatic logic [CNT_W-1:0] ptr_diff(input logic [PTR_W-1:0] t, input logic [PTR_W-1:0] h);
    logic [CNT_W-1:0] ti;
    logic [CNT_W-1:0] hi;
    ti = CNT_W'(t[IDX_W-1:0]);
    hi = CNT_W'(h[IDX_W-1:0]);
    if (t[PTR_W-1] != h[PTR_W-1]) ti = ti + CNT_W'(DEPTH);
    return ti - hi;
  endfunction

  function automatic logic [LN_W-1:0] popcnt(input logic [3:0] v);
    logic [LN_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < 4; i++) c = c + LN_W'(v[i]);
    return c;
  endfunction

  logic [PTAG_W-1:0]         entries [DEPTH];
  logic [PTR_W-1:0]          head, tail;
  logic [PTR_W-1:0]          cp_head [CHECKPOINT_DEPTH];
  logic [CHECKPOINT_DEPTH-1:0] cp_valid;

  logic [LN_W-1:0]  n_req, n_free, k_a, k_f;
  logic             grant, overflow, restore_ok;
  logic [CNT_W:0]   cnt_after;
  logic [PTR_W-1:0] head_alloc, head_nxt, tail_nxt, rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic [PTR_W-1:0] wr_ptr [FREE_PORTS];
  logic [FREE_PORTS-1:0] wr_en;

  // Grant, tag compaction, free placement and next pointer computation.
  always_comb begin
    alloc_tag  = '0;
    wr_en      = '0;
    k_a        = '0;
    k_f        = '0;
    rd_ptr     = head;
    for (int unsigned l = 0; l < FREE_PORTS; l++) wr_ptr[l] = tail;

    n_req       = popcnt(4'(alloc_req));
    n_free      = popcnt(4'(free_valid));
    alloc_ready = (CNT_W'(n_req) <= free_count) && !cp_restore;
    grant       = alloc_ready;

    for (int unsigned l = 0; l < ALLOC_PORTS; l++) begin
      if (alloc_req[l]) begin
        rd_ptr = ptr_add(head, k_a);
        alloc_tag[l*PTAG_W +: PTAG_W] = entries[rd_ptr[IDX_W-1:0]];
        k_a = k_a + LN_W'(1);
      end
    end

    head_alloc = grant ? ptr_add(head, n_req) : head;
    cnt_after  = {1'b0, free_count} - (grant ? (CNT_W+1)'(n_req) : '0) + (CNT_W+1)'(n_free);
    overflow   = cnt_after > (CNT_W+1)'(DEPTH);

    for (int unsigned l = 0; l < FREE_PORTS; l++) begin
      if (free_valid[l] && !overflow) begin
        wr_en[l]  = 1'b1;
        wr_ptr[l] = ptr_add(tail, k_f);
        k_f = k_f + LN_W'(1);
      end
    end

    tail_nxt   = overflow ? tail : ptr_add(tail, n_free);
    restore_ok = cp_restore && cp_valid[cp_idx];
    head_nxt   = restore_ok ? cp_head[cp_idx] : head_alloc;
    count_nxt  = ptr_diff(tail_nxt, head_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= PTAG_W'(ARCH_REGS + i);
      for (int unsigned i = 0; i < CHECKPOINT_DEPTH; i++) cp_head[i] <= '0;
      head            <= '0;
      tail            <= ptr_add('0, '0) + PTR_W'(0) | {1'b1, IDX_W'(0)};
      cp_valid        <= '0;
      free_count      <= CNT_W'(DEPTH);
      empty           <= (DEPTH == 0);
      err_overflow    <= 1'b0;
      err_bad_restore <= 1'b0;
    end else begin
      head       <= head_nxt;
      tail       <= tail_nxt;
      free_count <= count_nxt;
      empty      <= (count_nxt == '0);
      for (int unsigned l = 0; l < FREE_PORTS; l++)
        if (wr_en[l]) entries[wr_ptr[l][IDX_W-1:0]] <= free_tag[l*PTAG_W +: PTAG_W];
      if (overflow) err_overflow <= 1'b1;
      // A restore wins over a same-cycle save; a good restore flushes every slot.
      if (cp_restore) begin
        if (restore_ok) cp_valid <= '0;
        else            err_bad_restore <= 1'b1;
      end else if (cp_save) begin
        cp_valid[cp_idx] <= 1'b1;
        cp_head[cp_idx]  <= head_alloc;
      end
    end
  end

endmodule
